// File: rtl/register_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Optional statistics are enabled with the REG_WRITE_ARB_STATS_EN macro.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COOLDOWN
    } arb_state_t;

    localparam int STATS_WIDTH = 16;
    localparam int MAX_REQ     = 32;

    // Converts a one-hot vector into the index of its set bit (0 when empty).
    function automatic int onehot_to_index(input logic [MAX_REQ-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/register_write_arbiter_if.sv
// Request/grant bus between the requester blocks and the shared-register arbiter.
// The master side is the requester population, the slave side is the arbiter.
interface register_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) ();

    logic [NUM_REQ-1:0]            Req;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data;
    logic [NUM_REQ-1:0]            Grant;
    logic [DATA_WIDTH-1:0]         Reg_Data;
    logic                          Reg_Enable;
    logic                          Busy;

    modport master (
        output Req,
        output Req_Data,
        input  Grant,
        input  Reg_Data,
        input  Reg_Enable,
        input  Busy
    );

    modport slave (
        input  Req,
        input  Req_Data,
        output Grant,
        output Reg_Data,
        output Reg_Enable,
        output Busy
    );

endinterface

// File: rtl/register_write_arbiter_picker.sv
// Combinational round-robin picker: finds the first active request starting
// one position after the last-grant pointer and wrapping back to index 0.
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         winner_o,
    output logic                       valid_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    // Walk the requests in rotation order and keep only the first hit.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated data register among NUM_REQ
// requesters. Each grant writes the register for one cycle, then a cooldown
// of GAP_CYCLES cycles follows. Defining REG_WRITE_ARB_STATS_EN adds the
// Write_Count and Last_Owner statistics outputs.
module register_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    register_write_arbiter_if.slave    bus
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]     Write_Count,
    output logic [$clog2(NUM_REQ)-1:0] Last_Owner
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_t             state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       gapCnt_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [DATA_WIDTH-1:0]  regData_q;
    logic                   regEnable_q;
    logic                   busy_q;

    logic [NUM_REQ-1:0]     reqMasked;
    logic [NUM_REQ-1:0]     winner;
    logic                   winValid;
    logic [PTR_W-1:0]       winIdx;
    logic [DATA_WIDTH-1:0]  winData;
    logic                   launch;

    // The requester being granted this cycle still holds Req at the closing edge.
    assign reqMasked = bus.Req & ~grant_q;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (reqMasked),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (winValid)
    );

    assign winIdx = PTR_W'(onehot_to_index(MAX_REQ'(winner)));

    // Select the winner's data slice with a one-hot mux.
    always_comb begin
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winData = bus.Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A new grant may start from IDLE, back-to-back from GRANT when there is no
    // gap, or on the final cooldown edge so grants are spaced exactly 1+GAP_CYCLES.
    always_comb begin
        launch = 1'b0;
        case (state_q)
            IDLE:     launch = winValid;
            GRANT:    launch = winValid && (GAP_CYCLES == 0);
            COOLDOWN: launch = winValid && (gapCnt_q == '0);
            default:  launch = 1'b0;
        endcase
    end

    // Arbitration FSM with registered grant, register write and busy outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            gapCnt_q    <= '0;
            grant_q     <= '0;
            regEnable_q <= 1'b0;
            regData_q   <= '0;
            busy_q      <= 1'b0;
        end else if (launch) begin
            state_q     <= GRANT;
            ptr_q       <= winIdx;
            grant_q     <= winner;
            regEnable_q <= 1'b1;
            regData_q   <= winData;
            busy_q      <= 1'b1;
        end else begin
            grant_q     <= '0;
            regEnable_q <= 1'b0;
            case (state_q)
                GRANT: begin
                    if (GAP_CYCLES > 0) begin
                        state_q  <= COOLDOWN;
                        gapCnt_q <= CNT_W'(GAP_CYCLES - 1);
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    if (gapCnt_q == '0) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        gapCnt_q <= gapCnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Grant      = grant_q;
    assign bus.Reg_Enable = regEnable_q;
    assign bus.Reg_Data   = regData_q;
    assign bus.Busy       = busy_q;

`ifdef REG_WRITE_ARB_STATS_EN
    logic [STATS_WIDTH-1:0] writeCount_q;
    logic [PTR_W-1:0]       lastOwner_q;

    // Saturating count of register writes and index of the latest grantee.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            writeCount_q <= '0;
            lastOwner_q  <= '0;
        end else begin
            if (regEnable_q && (writeCount_q != '1)) begin
                writeCount_q <= writeCount_q + 1'b1;
            end
            if (launch) begin
                lastOwner_q <= winIdx;
            end
        end
    end

    assign Write_Count = writeCount_q;
    assign Last_Owner  = lastOwner_q;
`endif

endmodule
